// File: rtl/verinject_pkg.sv
// Shared definitions for the fault-injection sequencer: idle output value,
// sequencer state encoding and the canonical 32-bit-cycle request record.
package verinject_pkg;

  // Matches no real bit index, so every injector stays quiet.
  localparam logic [31:0] IDLE_STATE  = 32'hFFFF_FFFF;
  localparam int unsigned REQ_CYCLE_W = 32;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ARMED = 2'd1,
    SEQ_FIRE  = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [REQ_CYCLE_W-1:0] cycle;
    logic [31:0]            bit_idx;
  } inj_req_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/verinject_injection_sequencer_if.sv
// Request handshake between a campaign driver (master) and the sequencer (slave).
interface verinject_injection_sequencer_if #(
  parameter int unsigned CYCLE_W = 32
) ();

  logic               req_valid;
  logic               req_ready;
  logic [CYCLE_W-1:0] req_cycle;
  logic [31:0]        req_bit;

  modport master (
    output req_valid,
    output req_cycle,
    output req_bit,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_cycle,
    input  req_bit,
    output req_ready
  );

endinterface

// File: rtl/verinject_seq_fifo.sv
// Small synchronous FIFO with a combinational head read; push when full and
// pop when empty are ignored.
module verinject_seq_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/verinject_injection_sequencer.sv
// Timed fault-injection sequencer: buffers {cycle, bit} requests and pulses the
// bit index for one cycle when the campaign counter reaches it. Optional
// fired-injection counter is enabled by defining VERINJECT_SEQ_STATS_EN.
module verinject_injection_sequencer
  import verinject_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CYCLE_W    = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  verinject_injection_sequencer_if.slave req_if,
  output logic [31:0]                    verinject__injector_state,
  output logic [CYCLE_W-1:0]             cycle_count,
  output logic                           busy,
  output logic                           missed
`ifdef VERINJECT_SEQ_STATS_EN
  ,
  output logic [31:0]                    injections_done
`endif
);

  localparam logic [1:0] ST_IDLE  = SEQ_IDLE;
  localparam logic [1:0] ST_ARMED = SEQ_ARMED;
  localparam logic [1:0] ST_FIRE  = SEQ_FIRE;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [CYCLE_W-1:0] cycle;
    logic [31:0]        bit_idx;
  } req_t;

  localparam int unsigned ENTRY_W = $bits(req_t);

  logic [1:0]         state_q, state_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic [31:0]        inj_q, inj_d;
  logic               missed_q, missed_d;

  req_t               push_entry;
  req_t               head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   occ_next;
  logic               push;
  logic               pop;
  logic               fire;

  assign push_entry     = '{cycle: req_if.req_cycle, bit_idx: req_if.req_bit};
  assign push           = req_if.req_valid && !fifo_full;
  assign req_if.req_ready = !fifo_full;

  verinject_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Only the head is examined: equal cycle fires, a passed cycle is dropped.
  always_comb begin
    pop      = 1'b0;
    fire     = 1'b0;
    inj_d    = IDLE_STATE;
    missed_d = missed_q;
    cycle_d  = enable ? cycle_q + CYCLE_W'(1) : cycle_q;
    if (enable && !fifo_empty) begin
      if (head.cycle == cycle_q) begin
        pop   = 1'b1;
        fire  = 1'b1;
        inj_d = head.bit_idx;
      end else if (head.cycle < cycle_q) begin
        pop      = 1'b1;
        missed_d = 1'b1;
      end
    end
  end

  always_comb begin
    occ_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
    if (fire)                 state_d = ST_FIRE;
    else if (occ_next != '0)  state_d = ST_ARMED;
    else                      state_d = ST_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cycle_q  <= '0;
      inj_q    <= IDLE_STATE;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cycle_q  <= cycle_d;
      inj_q    <= inj_d;
      missed_q <= missed_d;
    end
  end

  assign verinject__injector_state = inj_q;
  assign cycle_count               = cycle_q;
  assign missed                    = missed_q;
  assign busy                      = (state_q != ST_IDLE) || !fifo_empty;

`ifdef VERINJECT_SEQ_STATS_EN
  logic [31:0] done_q, done_d;

  always_comb begin
    done_d = fire ? sat_inc32(done_q) : done_q;
  end

  always_ff @(posedge clock) begin
    if (reset) done_q <= '0;
    else       done_q <= done_d;
  end

  assign injections_done = done_q;
`else
  // Pulse entry is tracked only when the statistics counter is built in.
  logic unused_fire;
  assign unused_fire = fire;
`endif

endmodule

// File: tb/tb_verinject_injection_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the request/injection rules.
module tb_verinject_injection_sequencer;
  import verinject_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 32;

  logic clock = 1'b0;
  logic reset;
  logic enable;
  always #5 clock = ~clock;

  verinject_injection_sequencer_if #(.CYCLE_W(CW)) req_if ();

  logic [31:0]   inj_state;
  logic [CW-1:0] cycle_count;
  logic          busy;
  logic          missed;
`ifdef VERINJECT_SEQ_STATS_EN
  logic [31:0]   injections_done;
`endif

  verinject_injection_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .CYCLE_W    (CW)
  ) dut (
    .clock                     (clock),
    .reset                     (reset),
    .enable                    (enable),
    .req_if                    (req_if.slave),
    .verinject__injector_state (inj_state),
    .cycle_count               (cycle_count),
    .busy                      (busy),
    .missed                    (missed)
`ifdef VERINJECT_SEQ_STATS_EN
    ,
    .injections_done           (injections_done)
`endif
  );

  int    errors = 0;
  int    checks = 0;
  string phase  = "init";

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL [%s] %s: got %0h expected %0h", phase, tag, got, exp);
    end
  endtask

  // Reference model: list of accepted requests and the campaign counter.
  inj_req_t    mq[$];
  logic [31:0] m_cycle  = '0;
  logic [31:0] m_out    = IDLE_STATE;
  bit          m_firing = 1'b0;
  bit          m_missed = 1'b0;
  logic [31:0] m_done   = '0;
  bit          m_pushed = 1'b0;
  int          pulses   = 0;

  task automatic model_edge();
    bit          room;
    logic [31:0] nxt;
    bit          fired;
    inj_req_t    h;
    m_pushed = 1'b0;
    if (reset) begin
      mq.delete();
      m_cycle  = '0;
      m_out    = IDLE_STATE;
      m_firing = 1'b0;
      m_missed = 1'b0;
      m_done   = '0;
      return;
    end
    room  = (mq.size() < DEPTH);
    nxt   = IDLE_STATE;
    fired = 1'b0;
    if (enable && mq.size() != 0) begin
      h = mq[0];
      if (h.cycle == m_cycle) begin
        mq.delete(0);
        nxt   = h.bit_idx;
        fired = 1'b1;
        if (m_done != 32'hFFFF_FFFF) m_done = m_done + 1;
      end else if (h.cycle < m_cycle) begin
        mq.delete(0);
        m_missed = 1'b1;
      end
    end
    if (req_if.req_valid && room) begin
      mq.push_back('{cycle: req_if.req_cycle, bit_idx: req_if.req_bit});
      m_pushed = 1'b1;
    end
    if (enable) m_cycle = m_cycle + 1;
    m_out    = nxt;
    m_firing = fired;
  endtask

  task automatic compare_all();
    check("injector_state", inj_state, m_out);
    check("cycle_count", cycle_count, m_cycle);
    check("busy", busy, (mq.size() != 0) || m_firing);
    check("missed", missed, m_missed);
    check("req_ready", req_if.req_ready, mq.size() < DEPTH);
`ifdef VERINJECT_SEQ_STATS_EN
    check("injections_done", injections_done, m_done);
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    compare_all();
    if (inj_state != IDLE_STATE) pulses++;
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    enable           = 1'b0;
    req_if.req_valid = 1'b0;
    step();
    reset  = 1'b0;
    pulses = 0;
  endtask

  task automatic push(input logic [31:0] c, input logic [31:0] b);
    req_if.req_valid = 1'b1;
    req_if.req_cycle = c;
    req_if.req_bit   = b;
    step();
    req_if.req_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int          hits;
    logic [31:0] hit_cycle;
    bit          found;
    logic [31:0] last_rc;
    logic [31:0] cand;

    reset            = 1'b1;
    enable           = 1'b0;
    req_if.req_valid = 1'b0;
    req_if.req_cycle = '0;
    req_if.req_bit   = '0;
    #2;

    phase = "reset";
    do_reset();
    check("reset_state", inj_state, 32'hFFFF_FFFF);
    check("reset_ready", req_if.req_ready, 1'b1);

    phase = "single";
    do_reset();
    enable = 1'b1;
    push(32'd5, 32'd17);
    hits = 0;
    hit_cycle = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (inj_state == 32'd17) begin
        hits++;
        hit_cycle = cycle_count;
      end
    end
    check("pulse_cycle", hit_cycle, 32'd6);
    check("pulse_count", hits, 1);
    check("busy_after", busy, 1'b0);

    phase = "back_to_back";
    do_reset();
    push(32'd3, 32'd1);
    push(32'd4, 32'd2);
    push(32'd5, 32'd3);
    enable = 1'b1;
    run(10);
    check("pulses", pulses, 3);
    check("no_missed", missed, 1'b0);

    phase = "late";
    do_reset();
    enable = 1'b1;
    run(10);
    check("cycle_at_push", cycle_count, 32'd10);
    push(32'd2, 32'd9);
    run(4);
    check("late_missed", missed, 1'b1);
    check("late_pulses", pulses, 0);

    phase = "full";
    do_reset();
    push(32'd1, 32'd1);
    push(32'd2, 32'd2);
    push(32'd3, 32'd3);
    push(32'd4, 32'd4);
    check("ready_low_when_full", req_if.req_ready, 1'b0);
    req_if.req_valid = 1'b1;
    req_if.req_cycle = 32'd9;
    req_if.req_bit   = 32'd5;
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = m_pushed;
    end
    check("fifth_accepted", found, 1'b1);
    req_if.req_valid = 1'b0;
    run(15);
    check("full_pulses", pulses, 5);
    check("full_missed", missed, 1'b0);

    phase = "equal_cycles";
    do_reset();
    push(32'd7, 32'd4);
    push(32'd7, 32'd5);
    enable = 1'b1;
    run(12);
    check("eq_missed", missed, 1'b1);
    check("eq_pulses", pulses, 1);
`ifdef VERINJECT_SEQ_STATS_EN
    check("eq_done", injections_done, 32'd1);
`endif

    phase = "reset_in_fire";
    do_reset();
    push(32'd8, 32'd30);
    push(32'd20, 32'd31);
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = (inj_state == 32'd30);
    end
    check("fire_seen", found, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("idle_after_reset", inj_state, 32'hFFFF_FFFF);
    check("count_after_reset", cycle_count, 32'd0);
    check("empty_after_reset", busy, 1'b0);
    pulses = 0;
    run(25);
    check("lost_requests", pulses, 0);

    phase = "random";
    do_reset();
    last_rc = '0;
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 599) == 0);
      enable = ($urandom_range(0, 7) != 0);
      req_if.req_valid = ($urandom_range(0, 2) == 0);
      cand = m_cycle + $urandom_range(0, 7);
      cand = (cand >= 32'd2) ? cand - 32'd2 : cand;
      if (cand < last_rc) cand = last_rc;
      req_if.req_cycle = cand;
      req_if.req_bit   = $urandom & 32'h7FFF_FFFF;
      step();
      if (m_pushed) last_rc = cand;
      if (reset) last_rc = '0;
    end
    reset            = 1'b0;
    req_if.req_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
